// File: rtl/omem_pkg.sv
// Shared types, defaults and helpers for the omem frame packer.
package omem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2
   } omem_state_e;

   localparam int unsigned OMEM_DATA_W     = 8;
   localparam int unsigned OMEM_NCH        = 3;
   localparam int unsigned OMEM_DEPTH      = 192;
   localparam int unsigned OMEM_ADDR_W     = 8;
   localparam int unsigned OMEM_WORD_BYTES = 4;

   // Upper bound on channel count accepted by popcount.
   localparam int unsigned OMEM_MAX_NCH    = 16;

   // Number of set bits in a (zero-extended) enable vector.
   function automatic int unsigned popcount(input logic [OMEM_MAX_NCH-1:0] v);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < OMEM_MAX_NCH; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

endpackage

// File: rtl/omem_word_reg.sv
// Valid/ready output register: loads a packed word, holds it while
// stalled, and drops valid on the final transfer of a frame.
module omem_word_reg
   import omem_pkg::*;
#(
   parameter int unsigned DATA_W     = OMEM_DATA_W,
   parameter int unsigned WORD_BYTES = OMEM_WORD_BYTES,
   parameter int unsigned ADDR_W     = OMEM_ADDR_W
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         load_i,
   input  logic                         clear_i,
   input  logic [WORD_BYTES*DATA_W-1:0] data_i,
   input  logic [ADDR_W-1:0]            idx_i,
   output logic                         valid_o,
   output logic [WORD_BYTES*DATA_W-1:0] data_o,
   output logic [ADDR_W-1:0]            idx_o
);

   logic                         valid_q;
   logic [WORD_BYTES*DATA_W-1:0] data_q;
   logic [ADDR_W-1:0]            idx_q;

   // Load takes precedence; otherwise clear valid on the last handshake.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         idx_q   <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         idx_q   <= idx_i;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign idx_o   = idx_q;

endmodule

// File: rtl/omem_frame_packer.sv
// Output frame buffer: collects up to NCH bytes per cycle, then streams the
// frame as packed words over valid/ready.
// Optional macro OMEM_ZERO_FILL_EN: bytes never written in the current frame
// are emitted as zero instead of stale memory contents.
module omem_frame_packer
   import omem_pkg::*;
#(
   parameter int unsigned DATA_W     = OMEM_DATA_W,
   parameter int unsigned NCH        = OMEM_NCH,
   parameter int unsigned DEPTH      = OMEM_DEPTH,
   parameter int unsigned ADDR_W     = OMEM_ADDR_W,
   parameter int unsigned WORD_BYTES = OMEM_WORD_BYTES
) (
   input  logic                         I_OMEM_HCLK,
   input  logic                         I_OMEM_HRESET_N,
   input  logic                         I_OMEM_START,
   input  logic [ADDR_W:0]              I_OMEM_FRAME_LEN,
   input  logic [NCH-1:0]               I_OMEM_WE,
   input  logic [NCH*ADDR_W-1:0]        I_OMEM_WADDR,
   input  logic [NCH*DATA_W-1:0]        I_OMEM_PIXEL,
   input  logic                         I_OMEM_RD_READY,
   output logic                         O_OMEM_RD_VALID,
   output logic [WORD_BYTES*DATA_W-1:0] O_OMEM_WDATA,
   output logic [ADDR_W-1:0]            O_OMEM_WORD_IDX,
   output logic                         O_OMEM_BUSY,
   output logic                         O_OMEM_DONE,
   output logic                         O_OMEM_ERR
);

   localparam int unsigned MIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   omem_state_e state_q;
   logic [ADDR_W:0] len_q, wr_cnt_q, rd_ptr_q;
   logic err_q, busy_q, done_q;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] waddr [NCH];
   logic [NCH-1:0]    acc;
   logic              oor, coll;
   logic              len_ok, start_ok, err_set;
   int unsigned       wr_sum;
   logic              fill_done;
   logic [ADDR_W:0]   wr_cnt_d, nwords;
   logic              rd_valid, load, last_xfer;
   logic [MIDX_W-1:0] rd_idx;
   logic [WORD_BYTES*DATA_W-1:0] word_d;

   for (genvar k = 0; k < NCH; k++) begin : g_addr
      assign waddr[k] = I_OMEM_WADDR[k*ADDR_W +: ADDR_W];
   end

   // Per-channel acceptance, range and collision detection during FILL.
   always_comb begin
      acc  = '0;
      oor  = 1'b0;
      coll = 1'b0;
      for (int unsigned k = 0; k < NCH; k++) begin
         if (I_OMEM_WE[k]) begin
            if ({1'b0, waddr[k]} < len_q) acc[k] = 1'b1;
            else                          oor    = 1'b1;
         end
         for (int unsigned j = 0; j < k; j++) begin
            if (I_OMEM_WE[k] && I_OMEM_WE[j] && (waddr[k] == waddr[j])) coll = 1'b1;
         end
      end
      if (state_q != ST_FILL) begin
         acc  = '0;
         oor  = 1'b0;
         coll = 1'b0;
      end
   end

   // Start qualification, error sources, write count and drain control.
   always_comb begin
      len_ok    = (I_OMEM_FRAME_LEN != '0) &&
                  (32'(I_OMEM_FRAME_LEN) <= DEPTH) &&
                  ((32'(I_OMEM_FRAME_LEN) % WORD_BYTES) == 0);
      start_ok  = I_OMEM_START && (state_q == ST_IDLE) && len_ok;
      err_set   = (I_OMEM_START && (state_q == ST_IDLE) && !len_ok) ||
                  oor || coll ||
                  ((state_q != ST_FILL) && (|I_OMEM_WE));
      wr_sum    = 32'(wr_cnt_q) + popcount(OMEM_MAX_NCH'(acc));
      fill_done = (state_q == ST_FILL) && (wr_sum >= 32'(len_q));
      wr_cnt_d  = fill_done ? len_q : (ADDR_W+1)'(wr_sum);
      nwords    = (ADDR_W+1)'(32'(len_q) / WORD_BYTES);
      load      = (state_q == ST_DRAIN) && (!rd_valid || I_OMEM_RD_READY) &&
                  (rd_ptr_q < nwords);
      last_xfer = (state_q == ST_DRAIN) && rd_valid && I_OMEM_RD_READY &&
                  (rd_ptr_q == nwords);
   end

`ifdef OMEM_ZERO_FILL_EN
   logic [DEPTH-1:0] written_q;

   // Track which bytes of the current frame have been written.
   always_ff @(posedge I_OMEM_HCLK or negedge I_OMEM_HRESET_N) begin
      if (!I_OMEM_HRESET_N) begin
         written_q <= '0;
      end else if (start_ok) begin
         written_q <= '0;
      end else begin
         for (int unsigned k = 0; k < NCH; k++) begin
            if (acc[k]) written_q[MIDX_W'(waddr[k])] <= 1'b1;
         end
      end
   end
`endif

   // Gather the word at rd_ptr from byte storage, byte 0 in the LSBs.
   always_comb begin
      word_d = '0;
      rd_idx = '0;
      for (int unsigned b = 0; b < WORD_BYTES; b++) begin
         rd_idx = MIDX_W'(32'(rd_ptr_q) * WORD_BYTES + b);
         word_d[b*DATA_W +: DATA_W] = mem[rd_idx];
`ifdef OMEM_ZERO_FILL_EN
         if (!written_q[rd_idx]) word_d[b*DATA_W +: DATA_W] = '0;
`endif
      end
   end

   // Byte storage; ascending loop order lets the highest channel win a collision.
   always_ff @(posedge I_OMEM_HCLK) begin
      for (int unsigned k = 0; k < NCH; k++) begin
         if (acc[k]) mem[MIDX_W'(waddr[k])] <= I_OMEM_PIXEL[k*DATA_W +: DATA_W];
      end
   end

   // Frame FSM with registered BUSY/DONE/ERR.
   always_ff @(posedge I_OMEM_HCLK or negedge I_OMEM_HRESET_N) begin
      if (!I_OMEM_HRESET_N) begin
         state_q  <= ST_IDLE;
         len_q    <= '0;
         wr_cnt_q <= '0;
         rd_ptr_q <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (err_set)       err_q <= 1'b1;
         else if (start_ok) err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_ok) begin
                  state_q  <= ST_FILL;
                  len_q    <= I_OMEM_FRAME_LEN;
                  wr_cnt_q <= '0;
                  rd_ptr_q <= '0;
                  busy_q   <= 1'b1;
               end
            end
            ST_FILL: begin
               wr_cnt_q <= wr_cnt_d;
               if (fill_done) state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (load) rd_ptr_q <= rd_ptr_q + 1'b1;
               if (last_xfer) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   omem_word_reg #(
      .DATA_W    (DATA_W),
      .WORD_BYTES(WORD_BYTES),
      .ADDR_W    (ADDR_W)
   ) u_word_reg (
      .clk_i  (I_OMEM_HCLK),
      .rst_ni (I_OMEM_HRESET_N),
      .load_i (load),
      .clear_i(last_xfer),
      .data_i (word_d),
      .idx_i  (rd_ptr_q[ADDR_W-1:0]),
      .valid_o(rd_valid),
      .data_o (O_OMEM_WDATA),
      .idx_o  (O_OMEM_WORD_IDX)
   );

   assign O_OMEM_RD_VALID = rd_valid;
   assign O_OMEM_BUSY     = busy_q;
   assign O_OMEM_DONE     = done_q;
   assign O_OMEM_ERR      = err_q;

endmodule
